// File: rtl/regfile_mp.sv
// Multi-read-port register file with registered reads, optional zero register,
// optional write-to-read bypass and a sequencer that zeroes the array after reset.
module regfile_mp #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_NUM    = 32,
   parameter int RD_PORTS   = 2,
   parameter int ZERO_REG   = 1,
   parameter int BYPASS     = 1,
   localparam int AW        = $clog2(REG_NUM)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clr_req,
   output logic                           ready,
   input  logic [RD_PORTS*AW-1:0]         rd_addr,
   output logic [RD_PORTS*DATA_WIDTH-1:0] rd_data,
   input  logic [AW-1:0]                  wr_addr,
   input  logic [DATA_WIDTH-1:0]          wr_data,
   input  logic                           wr_en
);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   localparam logic [AW:0]   REG_NUM_W = (AW+1)'(REG_NUM);
   localparam logic [AW-1:0] PTR_LAST  = AW'(REG_NUM - 1);

   state_e                         state_q, state_d;
   logic [AW-1:0]                  ptr_q, ptr_d;
   logic [RD_PORTS*DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic [DATA_WIDTH-1:0]          regs_q [REG_NUM];
   logic                           wr_fire;

   function automatic logic in_range(input logic [AW-1:0] a);
      return {1'b0, a} < REG_NUM_W;
   endfunction

   // A write only lands in RUN; a same-cycle clr_req wins over it.
   always_comb begin
      wr_fire = (state_q == ST_RUN) && wr_en && !clr_req && in_range(wr_addr)
                && !((ZERO_REG != 0) && (wr_addr == '0));
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_CLEAR: begin
            if (ptr_q == PTR_LAST) begin
               state_d = ST_RUN;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (clr_req) begin
               state_d = ST_CLEAR;
               ptr_d   = '0;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            ptr_d   = '0;
         end
      endcase
   end

   always_comb begin
      logic [AW-1:0]         ra;
      logic [DATA_WIDTH-1:0] val;
      rd_data_d = '0;
      ra        = '0;
      val       = '0;
      if (state_q == ST_RUN) begin
         for (int p = 0; p < RD_PORTS; p++) begin
            ra = rd_addr[p*AW +: AW];
            if (!in_range(ra) || ((ZERO_REG != 0) && (ra == '0))) begin
               val = '0;
            end else if ((BYPASS != 0) && wr_fire && (ra == wr_addr)) begin
               val = wr_data;
            end else begin
               val = regs_q[ra];
            end
            rd_data_d[p*DATA_WIDTH +: DATA_WIDTH] = val;
         end
      end
   end

   // Storage has no reset; the CLEAR sweep is what zeroes it.
   always_ff @(posedge clk) begin
      if (state_q == ST_CLEAR) begin
         regs_q[ptr_q] <= '0;
      end else if (wr_fire) begin
         regs_q[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_CLEAR;
         ptr_q     <= '0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign ready   = (state_q == ST_RUN);
   assign rd_data = rd_data_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: drives a default build and a BYPASS=0/ZERO_REG=0 build
// with the same stimulus; a monitor pops expected read data from queues.
module tb_regfile_mp;

   logic        clk;
   logic        rst;
   logic        clr_req;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [9:0]  rd_addr;
   logic        rd_chk;
   logic        ready_a, ready_b;
   logic [63:0] rd_data_a, rd_data_b;

   logic [63:0] exp_a_q[$];
   logic [63:0] exp_b_q[$];
   string       name_q[$];

   int n_checks;
   int n_pass;

   regfile_mp dut_a (
      .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready_a),
      .rd_addr(rd_addr), .rd_data(rd_data_a),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en)
   );

   regfile_mp #(.ZERO_REG(0), .BYPASS(0)) dut_b (
      .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready_b),
      .rd_addr(rd_addr), .rd_data(rd_data_b),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // driver tasks
   task automatic issue(input logic cr, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] ra0, input logic [4:0] ra1,
                        input logic chk, input logic [31:0] ea0, input logic [31:0] ea1,
                        input logic [31:0] eb0, input logic [31:0] eb1, input string nm);
      @(negedge clk);
      clr_req = cr;
      wr_en   = we;
      wr_addr = wa;
      wr_data = wd;
      rd_addr = {ra1, ra0};
      rd_chk  = chk;
      if (chk) begin
         exp_a_q.push_back({ea1, ea0});
         exp_b_q.push_back({eb1, eb0});
         name_q.push_back(nm);
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      issue(1'b0, 1'b1, a, d, 5'd0, 5'd0, 1'b0, 0, 0, 0, 0, "");
   endtask

   task automatic rd(input logic [4:0] a0, input logic [4:0] a1, input logic [31:0] ea0,
                     input logic [31:0] ea1, input logic [31:0] eb0, input logic [31:0] eb1,
                     input string nm);
      issue(1'b0, 1'b0, 5'd0, 32'd0, a0, a1, 1'b1, ea0, ea1, eb0, eb1, nm);
   endtask

   task automatic idle();
      issue(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 0, 0, 0, 0, "");
   endtask

   // Releases rst, keeps writing addr 5 and reading addr 2/4, counts edges to ready.
   task automatic sweep_watch(input int clr_at, input string nm);
      int na, nb;
      na = 0;
      nb = 0;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         rst     = 1'b0;
         clr_req = (n == clr_at);
         wr_en   = 1'b1;
         wr_addr = 5'd5;
         wr_data = 32'hDEADBEEF;
         rd_addr = {5'd4, 5'd2};
         rd_chk  = 1'b1;
         exp_a_q.push_back(64'd0);
         exp_b_q.push_back(64'd0);
         name_q.push_back({nm, " sweep read"});
         @(posedge clk);
         #1;
         if (ready_a && na == 0) na = n;
         if (ready_b && nb == 0) nb = n;
         if (na != 0 && nb != 0) break;
      end
      check({nm, " ready edges a"}, 64'(na), 64'd32);
      check({nm, " ready edges b"}, 64'(nb), 64'd32);
   endtask

   // scoreboard monitor
   initial begin
      logic        fire;
      logic [63:0] ea, eb;
      string       nm;
      forever begin
         @(posedge clk);
         fire = rd_chk;
         #1;
         if (fire) begin
            if (exp_a_q.size() == 0) begin
               check("queue underflow", 64'd1, 64'd0);
            end else begin
               ea = exp_a_q.pop_front();
               eb = exp_b_q.pop_front();
               nm = name_q.pop_front();
               check({nm, " a"}, rd_data_a, ea);
               check({nm, " b"}, rd_data_b, eb);
            end
         end
      end
   end

   // stimulus
   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b1;
      clr_req  = 1'b0;
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      rd_addr  = '0;
      rd_chk   = 1'b0;
      repeat (3) @(negedge clk);
      check("reset ready a", 64'(ready_a), 64'd0);
      check("reset ready b", 64'(ready_b), 64'd0);
      check("reset rd_data a", rd_data_a, 64'd0);
      check("reset rd_data b", rd_data_b, 64'd0);

      // clear after reset, writes to addr 5 during CLEAR are dropped
      sweep_watch(0, "post-reset");
      rd(5'd5, 5'd5, 0, 0, 0, 0, "addr5 after clear");

      // basic write/read
      wr(5'd3, 32'h12345678);
      wr(5'd31, 32'hCAFEF00D);
      rd(5'd3, 5'd31, 32'h12345678, 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D, "basic rw");

      // read-during-write on addr 7
      wr(5'd7, 32'h1);
      issue(1'b0, 1'b1, 5'd7, 32'h2, 5'd7, 5'd3, 1'b1,
            32'h2, 32'h12345678, 32'h1, 32'h12345678, "bypass rdw");
      rd(5'd7, 5'd7, 32'h2, 32'h2, 32'h2, 32'h2, "bypass after");

      // zero register
      issue(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 0, 0, 0, 0, "zero rdw");
      rd(5'd0, 5'd0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, "zero later");

      // clr_req with a concurrent write, second clr_req mid-sweep
      wr(5'd1, 32'hA);
      wr(5'd2, 32'hB);
      wr(5'd3, 32'hC);
      wr(5'd4, 32'hD);
      rd(5'd1, 5'd2, 32'hA, 32'hB, 32'hA, 32'hB, "fill 1-2");
      rd(5'd3, 5'd4, 32'hC, 32'hD, 32'hC, 32'hD, "fill 3-4");
      issue(1'b1, 1'b1, 5'd2, 32'h99, 5'd0, 5'd0, 1'b1,
            0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, "clr cycle read");
      sweep_watch(10, "clr_req");
      rd(5'd1, 5'd2, 0, 0, 0, 0, "cleared 1-2");
      rd(5'd3, 5'd4, 0, 0, 0, 0, "cleared 3-4");
      rd(5'd0, 5'd5, 0, 0, 0, 0, "cleared 0,5");

      // async reset while in RUN with non-zero read data
      wr(5'd9, 32'h55AA55AA);
      rd(5'd9, 5'd9, 32'h55AA55AA, 32'h55AA55AA, 32'h55AA55AA, 32'h55AA55AA, "pre-reset read");
      @(posedge clk);
      #3;
      rst     = 1'b1;
      rd_chk  = 1'b0;
      wr_en   = 1'b0;
      #1;
      check("run async rst ready a", 64'(ready_a), 64'd0);
      check("run async rst rd_data a", rd_data_a, 64'd0);
      check("run async rst rd_data b", rd_data_b, 64'd0);

      // async reset at sweep cycle 10
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("sweep cycle 10 ready a", 64'(ready_a), 64'd0);
      #2;
      rst = 1'b1;
      #1;
      check("mid-sweep rst ready a", 64'(ready_a), 64'd0);
      check("mid-sweep rst ready b", 64'(ready_b), 64'd0);
      check("mid-sweep rst rd_data a", rd_data_a, 64'd0);
      @(negedge clk);
      sweep_watch(0, "after mid-sweep rst");
      rd(5'd9, 5'd9, 0, 0, 0, 0, "addr9 after rst");
      wr(5'd9, 32'h1);
      rd(5'd9, 5'd3, 32'h1, 32'h0, 32'h1, 32'h0, "final rw");
      idle();
      repeat (3) @(negedge clk);
      check("queue drained", 64'(exp_a_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
